// File: rtl/ivl_uvm_ovl_pkg.sv
// ----------------------------------------------------------------------------
// ivl_uvm_ovl_pkg
//   Shared definitions for the ovl_next responder:
//     - default parameter values (delay width, queue depth)
//     - responder state enumeration (IDLE / ACTIVE)
//     - timestamp width helper
// ----------------------------------------------------------------------------
package ivl_uvm_ovl_pkg;

    localparam int DEF_DLY_W = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } resp_state_e;

    // One bit wider than the delay field. The largest span between a push
    // and its due time (2**DLY_W-1) then stays below the wrap distance
    // (2**TS_W), so an equality compare on the wrapped timestamp is exact.
    function automatic int ts_width(input int dly_w);
        return dly_w + 1;
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_resp_fifo.sv
// ----------------------------------------------------------------------------
// ivl_uvm_ovl_resp_fifo
//   DEPTH x W synchronous FIFO holding due timestamps of outstanding requests.
//   Simultaneous push and pop are allowed, including when full (the pop
//   frees the slot the push fills). The caller guards push-when-full.
//   Besides the head entry it also exposes the entry behind the head so the
//   owner can look one pop ahead without an extra cycle.
//
// Ports
//   clk_i        in   clock, posedge
//   rst_i        in   asynchronous active-high reset (pointers/count only)
//   push_i       in   write push_data_i at the tail
//   push_data_i  in   W-bit entry
//   pop_i        in   drop the head entry
//   head_o       out  entry at the head (valid when !empty_o)
//   next_o       out  entry behind the head (valid when count_o >= 2)
//   full_o       out  count_o == DEPTH
//   empty_o      out  count_o == 0
//   count_o      out  number of stored entries
// ----------------------------------------------------------------------------
module ivl_uvm_ovl_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [W-1:0]               next_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [AW-1:0] rd_ptr_nxt;

    // DEPTH is a power of two, so pointer wrap is plain modulo arithmetic.
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only read once the count says
    // it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_nxt];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ivl_uvm_ovl_next_responder.sv
// ----------------------------------------------------------------------------
// ivl_uvm_ovl_next_responder
//   Responder side of a req->ack protocol for ovl_next unit tests. Every
//   accepted request (start_event) produces exactly one single-cycle ack
//   (test_expr) that is seen high at the clock edge D clocks after the
//   request edge, D = max(cfg_delay, 1). Overlapping requests are held as
//   due timestamps in a small FIFO; a request arriving while the FIFO is
//   full is dropped and flagged in the sticky overflow bit.
//
//   Optional feature, selected by macro IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN:
//   adds input err_inj. err_inj=1 at the edge before a due ack suppresses
//   that ack (the entry is still retired), so an attached ovl_next fires.
//
// Ports
//   clock        in   single clock, posedge
//   reset        in   asynchronous active-high reset, clears all state
//   enable       in   1 = accept new requests
//   start_event  in   request, sampled on posedge
//   cfg_delay    in   DLY_W-bit req->ack distance (0 behaves as 1)
//   err_inj      in   ack suppression (only with the macro above)
//   test_expr    out  ack, registered
//   busy         out  at least one request outstanding
//   outstanding  out  number of queued, not yet acked requests
//   overflow     out  sticky: a request was dropped because the queue was full
// ----------------------------------------------------------------------------
module ivl_uvm_ovl_next_responder
    import ivl_uvm_ovl_pkg::*;
#(
    parameter int DLY_W = DEF_DLY_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       start_event,
    input  logic [DLY_W-1:0]           cfg_delay,
`ifdef IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN
    input  logic                       err_inj,
`endif
    output logic                       test_expr,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       overflow
);

    localparam int TS_W = ts_width(DLY_W);
    localparam int CW   = $clog2(DEPTH + 1);

    logic [TS_W-1:0]  ts_q,  ts_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    resp_state_e      state_q, state_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;

    logic [TS_W-1:0]  head_due;
    logic [TS_W-1:0]  next_due;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic [DLY_W-1:0] cfg_eff;
    logic [DLY_W-1:0] dly_use;
    logic             req_v;
    logic             pop;
    logic             push;
    logic             drop;
    logic [TS_W-1:0]  push_due;
    logic             nh_vld;
    logic [TS_W-1:0]  nh_due;
    logic             inj;

`ifdef IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN
    assign inj = err_inj;
`else
    assign inj = 1'b0;
`endif

    // A delay of zero would need a combinational req->ack path; treat as 1.
    assign cfg_eff = (cfg_delay == '0) ? DLY_W'(1) : cfg_delay;

    // The live delay is only taken while nothing is queued. Holding it
    // constant while busy keeps due times strictly increasing in push
    // order, so the FIFO head is always the earliest due entry.
    assign dly_use = fifo_empty ? cfg_eff : dly_q;

    assign req_v    = start_event & enable;
    assign pop      = !fifo_empty && (head_due == ts_q);
    assign push     = req_v && (!fifo_full || pop);
    assign drop     = req_v && fifo_full && !pop;
    assign push_due = ts_q + TS_W'(dly_use);
    assign ts_d     = ts_q + TS_W'(1);

    // Head of the queue as it will stand after this edge. The ack register
    // is loaded one edge ahead of the pop so test_expr is already high when
    // the due edge samples it.
    always_comb begin
        nh_vld = 1'b0;
        nh_due = head_due;
        if (!fifo_empty && !pop) begin
            nh_vld = 1'b1;
            nh_due = head_due;
        end else if (pop && (fifo_count > CW'(1))) begin
            nh_vld = 1'b1;
            nh_due = next_due;
        end else if (push) begin
            nh_vld = 1'b1;
            nh_due = push_due;
        end
    end

    always_comb begin
        ack_d   = nh_vld && (nh_due == ts_d) && !inj;
        dly_d   = dly_use;
        ovf_d   = ovf_q | drop;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pop && !push && (fifo_count == CW'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q    <= '0;
            dly_q   <= DLY_W'(1);
            state_q <= IDLE;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            dly_q   <= dly_d;
            state_q <= state_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    ivl_uvm_ovl_resp_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i (push_due),
        .pop_i       (pop),
        .head_o      (head_due),
        .next_o      (next_due),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign test_expr   = ack_q;
    assign busy        = (state_q == ACTIVE);
    assign outstanding = fifo_count;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_next_responder.sv
// ----------------------------------------------------------------------------
// tb_ivl_uvm_ovl_next_responder
//   Directed bench for the ovl_next responder (DLY_W=4, DEPTH=4).
//   Inputs change 1 ns after a rising edge; outputs are read at that same
//   point, i.e. a value read after edge n is what edge n+1 samples.
// ----------------------------------------------------------------------------
module tb_ivl_uvm_ovl_next_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       start_event = 1'b0;
    logic [3:0] cfg_delay = 4'd1;
`ifdef IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN
    logic       err_inj = 1'b0;
`endif
    logic       test_expr;
    logic       busy;
    logic [2:0] outstanding;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ivl_uvm_ovl_next_responder #(
        .DLY_W (4),
        .DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start_event (start_event),
        .cfg_delay   (cfg_delay),
`ifdef IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN
        .err_inj     (err_inj),
`endif
        .test_expr   (test_expr),
        .busy        (busy),
        .outstanding (outstanding),
        .overflow    (overflow)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (test_expr !== 1'b0) begin
            n_fail++; $display("FAIL reset_ack: got %b want 0", test_expr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (outstanding !== 3'd0) begin
            n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    // D=1: ack seen at the very next edge, single cycle
    task automatic test_single_d1();
        cfg_delay = 4'd1;
        start_event = 1'b1;
        tick();
        start_event = 1'b0;
        n_checks++;
        if (test_expr !== 1'b1 || outstanding !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_ack_cycle: ack=%b out=%0d busy=%b want 1/1/1", test_expr, outstanding, busy);
        end
        tick();
        n_checks++;
        if (test_expr !== 1'b0 || outstanding !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_after: ack=%b out=%0d busy=%b want 0/0/0", test_expr, outstanding, busy);
        end
        tick();
        n_checks++;
        if (test_expr !== 1'b0) begin
            n_fail++; $display("FAIL d1_single: ack=%b want 0", test_expr);
        end
    endtask

    // D=0 behaves as D=1
    task automatic test_zero_delay();
        cfg_delay = 4'd0;
        start_event = 1'b1;
        tick();
        start_event = 1'b0;
        n_checks++;
        if (test_expr !== 1'b1) begin
            n_fail++; $display("FAIL d0_as_d1: ack=%b want 1", test_expr);
        end
        tick();
        n_checks++;
        if (test_expr !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL d0_after: ack=%b out=%0d want 0/0", test_expr, outstanding);
        end
        tick();
    endtask

    // D=3, three back-to-back requests
    task automatic test_overlap_d3();
        logic [5:0] req_v = 6'b000111;
        logic [5:0] ack_v = 6'b011100;
        int exp_out [6] = '{1, 2, 3, 2, 1, 0};
        cfg_delay = 4'd3;
        for (int i = 0; i < 6; i++) begin
            start_event = req_v[i];
            tick();
            n_checks++;
            if (test_expr !== ack_v[i] || outstanding !== 3'(exp_out[i])) begin
                n_fail++;
                $display("FAIL overlap_d3[%0d]: ack=%b out=%0d want %b/%0d",
                         i, test_expr, outstanding, ack_v[i], exp_out[i]);
            end
        end
        start_event = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL overlap_d3_busy: got %b want 0", busy);
        end
        tick();
    endtask

    // D=8, request held 6 cycles: 4 accepted, 2 dropped
    task automatic test_overflow();
        int acks = 0;
        cfg_delay = 4'd8;
        for (int i = 0; i < 14; i++) begin
            start_event = (i < 6);
            tick();
            if (test_expr === 1'b1) acks++;
            n_checks++;
            if (test_expr !== ((i >= 7 && i <= 10) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL ovf_ack[%0d]: ack=%b", i, test_expr);
            end
            if (i == 3) begin
                n_checks++;
                if (overflow !== 1'b0 || outstanding !== 3'd4) begin
                    n_fail++; $display("FAIL ovf_full: ovf=%b out=%0d want 0/4", overflow, outstanding);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (overflow !== 1'b1 || outstanding !== 3'd4) begin
                    n_fail++; $display("FAIL ovf_set: ovf=%b out=%0d want 1/4", overflow, outstanding);
                end
            end
        end
        start_event = 1'b0;
        n_checks++;
        if (acks != 4) begin
            n_fail++; $display("FAIL ovf_ack_count: got %0d want 4", acks);
        end
        n_checks++;
        if (overflow !== 1'b1 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL ovf_sticky: ovf=%b out=%0d want 1/0", overflow, outstanding);
        end
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_cleared: got %b want 0", overflow);
        end
        tick();
    endtask

    // D=5, request then asynchronous reset before the ack is due
    task automatic test_reset_mid();
        cfg_delay = 4'd5;
        start_event = 1'b1;
        tick();
        start_event = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (test_expr !== 1'b0 || busy !== 1'b0 || outstanding !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: ack=%b busy=%b out=%0d ovf=%b want all 0",
                     test_expr, busy, outstanding, overflow);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (test_expr !== 1'b0 || outstanding !== 3'd0) begin
                n_fail++; $display("FAIL midrst_no_ack[%0d]: ack=%b out=%0d want 0/0", i, test_expr, outstanding);
            end
        end
    endtask

    // enable=0 ignores requests; delay change while busy is held off
    task automatic test_enable_and_latch();
        enable = 1'b0;
        cfg_delay = 4'd2;
        start_event = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        start_event = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (test_expr !== 1'b0 || outstanding !== 3'd0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL en0[%0d]: ack=%b out=%0d ovf=%b want 0/0/0", i, test_expr, outstanding, overflow);
            end
        end
        enable = 1'b1;
        start_event = 1'b1;
        tick();
        cfg_delay = 4'd6;
        tick();
        start_event = 1'b0;
        n_checks++;
        if (test_expr !== 1'b1 || outstanding !== 3'd2) begin
            n_fail++; $display("FAIL latch_first: ack=%b out=%0d want 1/2", test_expr, outstanding);
        end
        tick();
        n_checks++;
        if (test_expr !== 1'b1) begin
            n_fail++; $display("FAIL latch_second: ack=%b want 1", test_expr);
        end
        tick();
        n_checks++;
        if (test_expr !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL latch_done: ack=%b out=%0d want 0/0", test_expr, outstanding);
        end
        // queue empty again: the new delay of 6 now applies
        start_event = 1'b1;
        tick();
        start_event = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (test_expr !== ((i == 5) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL d6_ack[%0d]: ack=%b", i, test_expr);
            end
        end
    endtask

    // D=4, continuous request: continuous ack, push+pop at full never drops
    task automatic test_back_to_back();
        int exp_out;
        cfg_delay = 4'd4;
        for (int i = 0; i < 14; i++) begin
            start_event = (i < 10);
            tick();
            exp_out = (i <= 3) ? i + 1 : ((i <= 9) ? 4 : 13 - i);
            n_checks++;
            if (test_expr !== ((i >= 3 && i <= 12) ? 1'b1 : 1'b0) || outstanding !== 3'(exp_out)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: ack=%b out=%0d want out %0d", i, test_expr, outstanding, exp_out);
            end
        end
        start_event = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_overflow: got %b want 0", overflow);
        end
        tick();
    endtask

`ifdef IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN
    task automatic test_err_inj();
        cfg_delay = 4'd2;
        start_event = 1'b1;
        tick();
        start_event = 1'b0;
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        n_checks++;
        if (test_expr !== 1'b0 || outstanding !== 3'd1) begin
            n_fail++; $display("FAIL errinj_suppress: ack=%b out=%0d want 0/1", test_expr, outstanding);
        end
        tick();
        n_checks++;
        if (test_expr !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL errinj_popped: ack=%b out=%0d want 0/0", test_expr, outstanding);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_d1();
        test_zero_delay();
        test_overlap_d3();
        test_overflow();
        test_reset_mid();
        test_enable_and_latch();
        test_back_to_back();
`ifdef IVL_UVM_OVL_NEXT_RESP_ERR_INJ_EN
        test_err_inj();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
